// File: rtl/screen_print_if.sv
// Bundle between the printer clients, the print scheduler and the character buffer write port.
// Interface shared by the printer clients, the scheduler and the character buffer write port.
interface screen_print_if #(
    parameter int unsigned NUM_PRINTERS = 4
);
    logic [NUM_PRINTERS-1:0]   req;
    logic [NUM_PRINTERS-1:0]   pr_finish;
    logic [NUM_PRINTERS-1:0]   pr_we;
    logic [8*NUM_PRINTERS-1:0] pr_index;
    logic [8*NUM_PRINTERS-1:0] pr_data;
    logic [NUM_PRINTERS-1:0]   pr_start;
    logic                      wr_en;
    logic [7:0]                wr_addr;
    logic [7:0]                wr_data;
    logic                      busy;
    logic [2:0]                grant;
    logic [NUM_PRINTERS-1:0]   timeout_err;

    // Scheduler side: takes client requests/writes, drives starts and the buffer port.
    modport master (
        input  req, pr_finish, pr_we, pr_index, pr_data,
        output pr_start, wr_en, wr_addr, wr_data, busy, grant, timeout_err
    );

    // Client/buffer side.
    modport slave (
        output req, pr_finish, pr_we, pr_index, pr_data,
        input  pr_start, wr_en, wr_addr, wr_data, busy, grant, timeout_err
    );
endinterface

// File: rtl/screen_print_scheduler.sv
// Round-robin arbiter sharing the character-buffer write port among several printer clients.
// Pending bits come from request pulses and a periodic refresh tick.
module screen_print_scheduler #(
    parameter int unsigned NUM_PRINTERS   = 4,
    parameter int unsigned REFRESH_CYCLES = 50000000,
    parameter int unsigned ACK_TIMEOUT    = 8
) (
    input  logic           clock,
    input  logic           resetn,
    screen_print_if.master bus
);
    localparam int unsigned IW = $clog2(NUM_PRINTERS);
    localparam int unsigned RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ACK,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_PRINTERS-1:0] pending_q, pending_d;
    logic [NUM_PRINTERS-1:0] pend_clr;
    logic [IW-1:0]           gidx_q, gidx_d;
    logic [IW-1:0]           rr_q, rr_d;
    logic [TW-1:0]           tcnt_q, tcnt_d;
    logic [NUM_PRINTERS-1:0] terr_q, terr_d;
    logic [NUM_PRINTERS-1:0] start_q, start_d;
    logic                    wr_en_q, wr_en_d;
    logic [7:0]              wr_addr_q, wr_addr_d;
    logic [7:0]              wr_data_q, wr_data_d;
    logic                    busy_q, busy_d;
    logic                    fwd;
    logic                    tick;

    logic                    pick_valid;
    logic [IW-1:0]           pick;
    logic [IW-1:0]           cand_idx;
    int unsigned             cand;

    logic [NUM_PRINTERS-1:0] sel_mask;
    logic                    fin_sel;
    logic                    we_sel;
    logic [7:0]              idx_sel;
    logic [7:0]              data_sel;

    // Free-running refresh counter; the wrap cycle requests every client.
    generate
        if (REFRESH_CYCLES != 0) begin : g_refresh
            logic [RW-1:0] rcnt_q;
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    rcnt_q <= '0;
                end else if (rcnt_q == RW'(REFRESH_CYCLES - 1)) begin
                    rcnt_q <= '0;
                end else begin
                    rcnt_q <= rcnt_q + RW'(1);
                end
            end
            assign tick = (rcnt_q == RW'(REFRESH_CYCLES - 1));
        end else begin : g_no_refresh
            assign tick = 1'b0;
        end
    endgenerate

    // First pending client at or after the round-robin pointer, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned k = 0; k < NUM_PRINTERS; k++) begin
            cand     = (32'(rr_q) + k) % NUM_PRINTERS;
            cand_idx = IW'(cand);
            if (!pick_valid && pending_q[cand_idx]) begin
                pick_valid = 1'b1;
                pick       = cand_idx;
            end
        end
    end

    assign sel_mask = NUM_PRINTERS'(1) << gidx_q;
    assign fin_sel  = bus.pr_finish[gidx_q];
    assign we_sel   = bus.pr_we[gidx_q];
    assign idx_sel  = bus.pr_index[{gidx_q, 3'b000} +: 8];
    assign data_sel = bus.pr_data[{gidx_q, 3'b000} +: 8];

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        gidx_d    = gidx_q;
        rr_d      = rr_q;
        tcnt_d    = tcnt_q;
        terr_d    = terr_q;
        start_d   = '0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        pend_clr  = '0;
        fwd       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    gidx_d  = pick;
                    start_d = NUM_PRINTERS'(1) << pick;
                    state_d = S_START;
                end
            end
            S_START: begin
                pend_clr = sel_mask;
                tcnt_d   = '0;
                state_d  = S_ACK;
            end
            S_ACK: begin
                fwd = 1'b1;
                if (!fin_sel) begin
                    state_d = S_RUN;
                end else if (tcnt_q == TW'(ACK_TIMEOUT - 1)) begin
                    terr_d  = terr_q | sel_mask;
                    state_d = S_DONE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_RUN: begin
                fwd = 1'b1;
                if (fin_sel) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                rr_d    = (gidx_q == IW'(NUM_PRINTERS - 1)) ? '0 : gidx_q + IW'(1);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The write that coincides with finish rising is still forwarded.
        if (fwd) begin
            wr_en_d   = we_sel;
            wr_addr_d = idx_sel;
            wr_data_d = data_sel;
        end

        // A new request or tick in the clearing cycle keeps the bit set.
        pending_d = (pending_q & ~pend_clr) | bus.req | {NUM_PRINTERS{tick}};
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            gidx_q    <= '0;
            rr_q      <= '0;
            tcnt_q    <= '0;
            terr_q    <= '0;
            start_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            gidx_q    <= gidx_d;
            rr_q      <= rr_d;
            tcnt_q    <= tcnt_d;
            terr_q    <= terr_d;
            start_q   <= start_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.pr_start    = start_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.busy        = busy_q;
    assign bus.grant       = 3'(gidx_q);
    assign bus.timeout_err = terr_q;
endmodule
